// File: rtl/load_store_unit.sv
// load_store_unit: byte-addressed load/store front end for a word-addressed
// data memory. Checks alignment, performs read-modify-write for sub-word
// stores and extends sub-word loads to 32 bits.
//
// Build option: define LSU_SUBWORD_EN to support byte and halfword accesses.
// Without it only aligned word accesses are legal and the read-before-write
// path, lane merge and extension logic are not built.
//
// state | meaning
// IDLE  | ready for a request (req_ready = 1)
// RD    | memory word being read into rd_buf (loads, sub-word stores)
// WR    | mem_write asserted with final write data
// RESP  | one-cycle response pulse
module load_store_unit #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      state;
  logic        mem_write_q;
  logic        load_q;
  logic [31:0] rd_buf;
  logic        req_err;

`ifdef LSU_SUBWORD_EN
  logic [1:0]  size_q;
  logic        signed_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q;

  // Select the addressed lane of a word and zero/sign extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] w,
                                               input logic [1:0]  lane,
                                               input logic [1:0]  sz,
                                               input logic        sg);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lane[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   r = {{24{sg & b[7]}}, b};
      2'b01:   r = {{16{sg & h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Insert right-aligned store data into its lane of the old word.
  function automatic logic [31:0] store_merge(input logic [31:0] old,
                                              input logic [31:0] wd,
                                              input logic [1:0]  lane,
                                              input logic [1:0]  sz);
    logic [31:0] m;
    m = old;
    if (sz == 2'b00) begin
      case (lane)
        2'd0:    m[7:0]   = wd[7:0];
        2'd1:    m[15:8]  = wd[7:0];
        2'd2:    m[23:16] = wd[7:0];
        default: m[31:24] = wd[7:0];
      endcase
    end else if (sz == 2'b01) begin
      if (lane[1]) m[31:16] = wd[15:0];
      else         m[15:0]  = wd[15:0];
    end else begin
      m = wd;
    end
    return m;
  endfunction
`else
  // Sign control only matters for sub-word loads, which this build rejects.
  logic unused_signed;
  assign unused_signed = req_signed;
`endif

  // Alignment and size legality of the incoming request.
  always_comb begin
    req_err = 1'b0;
`ifdef LSU_SUBWORD_EN
    req_err = (req_size == 2'b11) ||
              (req_size == 2'b01 && req_addr[0]) ||
              (req_size == 2'b10 && req_addr[1:0] != 2'b00);
`else
    req_err = (req_size != 2'b10) || (req_addr[1:0] != 2'b00);
`endif
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  // A synchronous reset still has to suppress the write strobe in its own cycle.
  assign mem_write  = mem_write_q & ~reset;

  // Load data is formed from rd_buf during the response cycle only.
  always_comb begin
    resp_rdata = 32'h0;
    if (resp_valid && load_q) begin
`ifdef LSU_SUBWORD_EN
      resp_rdata = load_extract(rd_buf, lane_q, size_q, signed_q);
`else
      resp_rdata = rd_buf;
`endif
    end
  end

  // Sequencer: request capture, memory read/write and response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      mem_write_q <= 1'b0;
      load_q      <= 1'b0;
      rd_buf      <= 32'h0;
      resp_err    <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= 32'h0;
`ifdef LSU_SUBWORD_EN
      size_q      <= 2'b00;
      signed_q    <= 1'b0;
      lane_q      <= 2'b00;
      wdata_q     <= 32'h0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            mem_addr <= req_addr[ADDR_W+1:2];
            load_q   <= ~req_write & ~req_err;
`ifdef LSU_SUBWORD_EN
            size_q   <= req_size;
            signed_q <= req_signed;
            lane_q   <= req_addr[1:0];
            wdata_q  <= req_wdata;
`endif
            if (req_err) begin
              resp_err <= 1'b1;
              state    <= RESP;
            end else if (!req_write) begin
              state <= RD;
            end else if (req_size == 2'b10) begin
              mem_wdata   <= req_wdata;
              mem_write_q <= 1'b1;
              state       <= WR;
            end else begin
              state <= RD;
            end
          end
        end
        RD: begin
          rd_buf <= mem_rdata;
`ifdef LSU_SUBWORD_EN
          if (load_q) begin
            state <= RESP;
          end else begin
            mem_wdata   <= store_merge(mem_rdata, wdata_q, lane_q, size_q);
            mem_write_q <= 1'b1;
            state       <= WR;
          end
`else
          state <= RESP;
`endif
        end
        WR: begin
          mem_write_q <= 1'b0;
          state       <= RESP;
        end
        default: begin
          resp_err <= 1'b0;
          load_q   <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a word-array memory, a reference
// model computing expected writes and responses from the access rules, and
// a monitor comparing DUT outputs against the expected queues.
module tb_load_store_unit;

`ifdef LSU_SUBWORD_EN
  localparam bit SUB = 1'b1;
`else
  localparam bit SUB = 1'b0;
`endif

  logic        clk = 0;
  logic        reset = 1;
  logic        req_valid = 0;
  logic        req_ready;
  logic        req_write = 0;
  logic [1:0]  req_size = 0;
  logic        req_signed = 0;
  logic [17:0] req_addr = 0;
  logic [31:0] req_wdata = 0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [15:0] mem_addr;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  load_store_unit #(.ADDR_W(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_write(mem_write), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem [0:65535];
  bit   [31:0] ref_mem [0:65535];
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;

  typedef struct { int cyc; logic [31:0] rdata; logic err; } resp_t;
  typedef struct { int cyc; logic [15:0] addr; logic [31:0] data; } wr_t;
  resp_t rq[$];
  wr_t   wq[$];

  int tests = 0;
  int fails = 0;
  int exp_next = 0;
  bit held = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: expected write and response for one accepted request.
  task automatic model(input int acc, input bit w, input bit [1:0] sz, input bit sg,
                       input bit [17:0] a, input bit [31:0] wd, output int lat);
    bit err;
    int wi, sh, wc;
    bit [31:0] old, v, mask, nw;
    wi  = int'(a >> 2);
    sh  = 8 * int'(a[1:0]);
    old = ref_mem[wi];
    if (SUB) err = (sz == 3) || (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 0);
    else     err = (sz != 2) || (a[1:0] != 0);
    if (err) begin
      rq.push_back('{acc + 1, 32'h0, 1'b1});
      lat = 1;
    end else if (!w) begin
      v = old >> sh;
      if (sz == 0) begin
        v = v & 32'hFF;
        if (sg && v[7]) v = v | 32'hFFFF_FF00;
      end else if (sz == 1) begin
        v = v & 32'hFFFF;
        if (sg && v[15]) v = v | 32'hFFFF_0000;
      end
      rq.push_back('{acc + 2, v, 1'b0});
      lat = 2;
    end else begin
      if (sz == 2) begin
        nw = wd; wc = acc + 1; lat = 2;
      end else begin
        mask = ((sz == 0) ? 32'hFF : 32'hFFFF) << sh;
        nw = (old & ~mask) | ((wd << sh) & mask);
        wc = acc + 2; lat = 3;
      end
      ref_mem[wi] = nw;
      wq.push_back('{wc, wi[15:0], nw});
      rq.push_back('{wc + 1, 32'h0, 1'b0});
    end
  endtask

  // Present a request and hold it until accepted; req_valid is left high.
  task automatic do_req(input bit w, input bit [1:0] sz, input bit sg, input bit [17:0] a,
                        input bit [31:0] wd, input bit track);
    int waited = 0;
    int acc, lat;
    bit chained = held;
    req_valid = 1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    do begin
      @(negedge clk);
      waited++;
      if (chained && waited == 1) check("ready_busy", {31'b0, req_ready}, 32'd0);
    end while (!req_ready && waited < 20);
    if (!req_ready) begin
      fails++; tests++;
      $display("FAIL accept_timeout: got ready %b expected 1", req_ready);
    end
    acc = cyc;
    if (chained) check("accept_cycle", acc, exp_next);
    if (track) begin
      model(acc, w, sz, sg, a, wd, lat);
      exp_next = acc + lat + 1;
    end
    @(posedge clk); #1;
    held = 1;
  endtask

  task automatic idle(input int n);
    req_valid = 0;
    held = 0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compares every write strobe and response against the queues.
  initial begin
    wr_t   ew;
    resp_t er;
    forever begin
      @(negedge clk);
      if (mem_write) begin
        if (wq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_write: got addr %h data %h expected none", mem_addr, mem_wdata);
        end else begin
          ew = wq.pop_front();
          check("write_cycle", cyc, ew.cyc);
          check("write_addr", {16'h0, mem_addr}, {16'h0, ew.addr});
          check("write_data", mem_wdata, ew.data);
        end
      end
      if (resp_valid) begin
        if (rq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_resp: got rdata %h err %b expected none", resp_rdata, resp_err);
        end else begin
          er = rq.pop_front();
          check("resp_cycle", cyc, er.cyc);
          check("resp_rdata", resp_rdata, er.rdata);
          check("resp_err", {31'b0, resp_err}, {31'b0, er.err});
        end
      end else begin
        check("idle_outputs", {resp_rdata[31:1], resp_rdata[0] | resp_err}, 32'h0);
      end
    end
  end

  initial begin
    int budget;
    bit [31:0] v;
    for (int i = 0; i < 65536; i++) begin mem[i] = 0; ref_mem[i] = 0; end
    for (int i = 0; i < 16; i++) begin
      v = $urandom; mem[i] = v; ref_mem[i] = v;
    end
    v = $urandom; mem[65535] = v; ref_mem[65535] = v;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_mem_write", {31'b0, mem_write}, 32'd0);
    check("rst_mem_addr", {16'h0, mem_addr}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    @(posedge clk); #1;
    reset = 0;
    idle(1);

    do_req(1, 2'b10, 0, 18'h00008, 32'hDEADBEEF, 1); idle(1);
    do_req(0, 2'b10, 0, 18'h00008, 32'h0, 1);        idle(1);
    do_req(1, 2'b10, 0, 18'h00008, 32'h11223344, 1); idle(1);
    do_req(1, 2'b00, 0, 18'h0000A, 32'h000000AA, 1); idle(1);
    do_req(0, 2'b00, 1, 18'h0000A, 32'h0, 1);        idle(1);
    do_req(0, 2'b00, 0, 18'h0000A, 32'h0, 1);        idle(1);
    do_req(0, 2'b01, 1, 18'h0000A, 32'h0, 1);        idle(1);
    do_req(1, 2'b01, 0, 18'h00003, 32'h12345678, 1); idle(1);
    do_req(0, 2'b10, 0, 18'h00006, 32'h0, 1);        idle(1);
    do_req(1, 2'b00, 0, 18'h3FFFF, 32'h0000005A, 1); idle(1);
    do_req(0, 2'b00, 1, 18'h3FFFF, 32'h0, 1);        idle(4);

    // Reset during the write cycle drops the access and its response.
    if (SUB) begin
      do_req(1, 2'b00, 0, 18'h00004, 32'h000000C3, 0);
      req_valid = 0; held = 0;
      @(posedge clk); #1;
    end else begin
      do_req(1, 2'b10, 0, 18'h00004, 32'hC3C3C3C3, 0);
      req_valid = 0; held = 0;
    end
    reset = 1;
    @(negedge clk);
    check("rst_wr_mem_write", {31'b0, mem_write}, 32'd0);
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    check("rst_wr_ready", {31'b0, req_ready}, 32'd1);
    check("rst_wr_no_resp", {31'b0, resp_valid}, 32'd0);
    idle(1);

    // Back-to-back pair with valid held high, then randomized traffic.
    do_req(1, 2'b10, 0, 18'h0000C, 32'hCAFEF00D, 1);
    do_req(0, 2'b10, 0, 18'h0000C, 32'h0, 1);
    for (int n = 0; n < 300; n++) begin
      bit [17:0] a;
      a = ($urandom_range(0, 15) == 0) ? 18'h3FFFF - 18'($urandom_range(0, 3))
                                        : 18'($urandom_range(0, 63));
      do_req($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
             a, $urandom, 1);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 4));
    end
    idle(1);

    budget = 0;
    while ((rq.size() != 0 || wq.size() != 0) && budget < 20) begin
      @(posedge clk); budget++;
    end
    @(negedge clk);
    check("pending_resp", rq.size(), 0);
    check("pending_write", wq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits between the core's execute stage and the word-addressed data memory, directly upstream of it. Accepts one byte-addressed load/store request at a time, checks alignment, and drives the memory's word address, write strobe and write data. Performs read-modify-write for byte and halfword stores. Returns loaded data zero- or sign-extended to 32 bits.

## Interface
Parameters:
- ADDR_W, 16: memory word-address width. The request byte address is ADDR_W+2 bits wide.

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
- req_signed  in  1  loads only: sign-extend byte/half
- req_addr  in  ADDR_W+2  byte address
- req_wdata  in  32  store data, right-aligned for byte/half
- resp_valid  out  1  one-cycle pulse per accepted request
- resp_rdata  out  32  load result; 0 for stores and errors
- resp_err  out  1  valid with resp_valid; misaligned or illegal size
- mem_addr  out  ADDR_W  word address, equal to the captured req_addr[ADDR_W+1:2]
- mem_write  out  1  memory write strobe
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, combinational from mem_addr

## Operation
- Little-endian lanes: byte k of a word occupies bits 8k+7:8k. Half 0 occupies 15:0 and half 1 occupies 31:16.
- On accept, capture write, size, signed, address and wdata in registers. The core may change its request inputs afterward.
- An error is flagged when size = 11, when size = half and addr[0] = 1, or when size = word and addr[1:0] ≠ 00.
- States: IDLE, RD, WR, RESP.
- Transitions from IDLE on accept:
  - error → RESP
  - load → RD
  - word store → WR
  - byte/half store → RD
- RD:
  - Register mem_rdata into rd_buf.
  - For a load, go to RESP.
  - For a sub-word store, go to WR.
- WR:
  - mem_write = 1.
  - mem_wdata is the store data shifted into its lane and merged with rd_buf. For a word store it is req_wdata unchanged.
  - Go to RESP.
- RESP:
  - resp_valid = 1 for exactly one cycle.
  - For loads, resp_rdata = selected lane, zero- or sign-extended from rd_buf.
  - Go to IDLE.
- resp_rdata and resp_err are 0 whenever resp_valid = 0.
- mem_write is asserted only in WR, and only while reset = 0.
- Responses have no backpressure; the core must take resp_valid when it occurs.

## Timing
- Reset values: state IDLE, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, mem_write = 0, mem_addr = 0, mem_wdata = 0, rd_buf = 0.
- Cycle numbering: the request is accepted at the edge ending cycle 0.
- Load: RD in cycle 1, resp_valid in cycle 2. Latency 2, throughput one request per 3 cycles.
- Word store: mem_write in cycle 1, resp_valid in cycle 2.
- Byte/half store: RD in cycle 1, mem_write in cycle 2, resp_valid in cycle 3.
- Error: resp_valid with resp_err = 1 in cycle 1; no memory access.
- req_ready is 0 from cycle 1 until the cycle after RESP. A request held high through RESP is accepted in the next IDLE cycle.
- Reset during any state returns to IDLE at the next edge and drops any response. If reset is high during WR, mem_write = 0 for that cycle.
- Highest byte address (all ones): byte access is legal and maps to word 2^ADDR_W−1, lane 3. There is no wrap.

## Configuration
- LSU_SUBWORD_EN defined: byte and half accesses are supported as described above.
- LSU_SUBWORD_EN undefined:
  - Only size = 10 is legal; any other size returns resp_err = 1.
  - The RD-before-WR path, the lane merge and the extension logic are not built.
  - Stores always go IDLE→WR→RESP.

## Test plan
- Reset, then word store 0xDEADBEEF to byte address 0x0008 → mem_write = 1 with mem_addr = 2 in cycle 1, resp_valid in cycle 2. A load of 0x0008 then returns 0xDEADBEEF, resp_err = 0.
- With word 2 = 0x11223344, byte store 0xAA to 0x000A (sub-word enabled) → mem_wdata = 0x11AA3344 in cycle 2, resp_valid in cycle 3.
- Signed byte load at 0x000A with word 2 = 0x11AA3344 → resp_rdata = 0xFFFFFFAA. With req_signed = 0 → 0x000000AA. Signed half load at 0x000A → 0x000011AA.
- Half store to 0x0003 and word load from 0x0006 → each gets resp_err = 1 in cycle 1, mem_write never asserted, resp_rdata = 0.
- Assert reset during the WR cycle of a byte store → mem_write = 0, no resp_valid, req_ready = 1 on the following cycle.
- Back-to-back requests with req_valid held high → req_ready = 0 while busy; the second request is accepted the cycle after the first resp_valid. Both responses are correct.
